// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core constants, port indices and the memory-port
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int CACHE_BLOCK_SIZE = 128;

    localparam logic MEM_PORT_IC = 1'b0;
    localparam logic MEM_PORT_DC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant; on a tie the port that did not
//               win last time is granted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import core_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last == MEM_PORT_DC) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serializes whole-block I-cache/D-cache transactions onto the
//               single external memory port with round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int BLOCK_W        = CACHE_BLOCK_SIZE,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            req_vld_i,
    input  logic [1:0]            req_wr_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*BLOCK_W-1:0]  req_data_i,
    output logic [1:0]            resp_vld_o,
    output logic [BLOCK_W-1:0]    resp_data_o,
    output logic                  mem_req_vld_o,
    input  logic                  mem_req_rdy_i,
    output logic                  mem_req_wr_o,
    output logic [ADDR_W-1:0]     mem_req_addr_o,
    output logic [BLOCK_W-1:0]    mem_req_data_o,
    input  logic                  mem_resp_vld_i,
    input  logic [BLOCK_W-1:0]    mem_resp_data_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int                c_CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO       = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'((BLOCK_W / 8) - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [1:0]          w_gnt;
    logic                w_sel;
    logic                w_req_wr;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [BLOCK_W-1:0]  w_req_data;
    logic                r_owner;
    logic                r_last_grant;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [BLOCK_W-1:0]  r_data;
    logic [BLOCK_W-1:0]  r_resp_data;
    logic [c_CNT_W-1:0]  r_tmo_cnt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                r_err;

    rr_arb2 u_rr_arb2 (
        .req  (req_vld_i),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    assign w_sel      = w_gnt[MEM_PORT_DC] ? MEM_PORT_DC : MEM_PORT_IC;
    assign w_req_wr   = req_wr_i[w_sel];
    assign w_req_addr = w_sel ? req_addr_i[ADDR_W +: ADDR_W]   : req_addr_i[0 +: ADDR_W];
    assign w_req_data = w_sel ? req_data_i[BLOCK_W +: BLOCK_W] : req_data_i[0 +: BLOCK_W];
    assign w_cnt_inc  = r_tmo_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|req_vld_i)     w_state_next = ISSUE;
            ISSUE:   if (mem_req_rdy_i)  w_state_next = WAIT;
            WAIT:    if (mem_resp_vld_i) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner      <= MEM_PORT_IC;
            r_last_grant <= MEM_PORT_DC;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_resp_data  <= '0;
            r_tmo_cnt    <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_vld_i) begin
                        r_owner <= w_sel;
                        r_wr    <= w_req_wr;
                        r_addr  <= w_req_addr & c_ALIGN_MASK;
                        r_data  <= w_req_data;
                    end
                end
                ISSUE: begin
                    r_tmo_cnt <= '0;
                end
                WAIT: begin
                    if (mem_resp_vld_i) begin
                        if (!r_wr) begin
                            r_resp_data <= mem_resp_data_i;
                        end
                    end else begin
                        // Counter saturates so the flag is raised once and stays put
                        if (r_tmo_cnt != c_TMO) begin
                            r_tmo_cnt <= w_cnt_inc;
                        end
                        if (w_cnt_inc == c_TMO) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_last_grant <= r_owner;
                end
                default: ;
            endcase
            if (mem_resp_vld_i && (r_state != WAIT)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req_vld_o  = (r_state == ISSUE);
    assign mem_req_wr_o   = r_wr;
    assign mem_req_addr_o = r_addr;
    assign mem_req_data_o = r_data;
    assign resp_vld_o     = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data_o    = r_resp_data;
    assign busy_o         = (r_state != IDLE);
    assign err_o          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int BW = 128;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [1:0]      req_vld_i;
    logic [1:0]      req_wr_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*BW-1:0] req_data_i;
    logic [1:0]      resp_vld_o;
    logic [BW-1:0]   resp_data_o;
    logic            mem_req_vld_o;
    logic            mem_req_rdy_i;
    logic            mem_req_wr_o;
    logic [AW-1:0]   mem_req_addr_o;
    logic [BW-1:0]   mem_req_data_o;
    logic            mem_resp_vld_i;
    logic [BW-1:0]   mem_resp_data_i;
    logic            busy_o;
    logic            err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_port_arbiter #(
        .ADDR_W         (AW),
        .BLOCK_W        (BW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_vld_i       (req_vld_i),
        .req_wr_i        (req_wr_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .resp_vld_o      (resp_vld_o),
        .resp_data_o     (resp_data_o),
        .mem_req_vld_o   (mem_req_vld_o),
        .mem_req_rdy_i   (mem_req_rdy_i),
        .mem_req_wr_o    (mem_req_wr_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_resp_vld_i  (mem_resp_vld_i),
        .mem_resp_data_i (mem_resp_data_i),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni          = 1'b0;
        req_vld_i       = 2'b00;
        req_wr_i        = 2'b00;
        req_addr_i      = '0;
        req_data_i      = '0;
        mem_req_rdy_i   = 1'b0;
        mem_resp_vld_i  = 1'b0;
        mem_resp_data_i = '0;
        repeat (2) tick();
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
        tests_run++; if (mem_req_vld_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_vld: got %b, expected 0", mem_req_vld_o); end
        tests_run++; if (resp_vld_o !== 2'b00) begin tests_failed++; $display("FAIL reset_resp_vld: got %b, expected 00", resp_vld_o); end
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b, expected 0", err_o); end
        tests_run++; if (resp_data_o !== '0) begin tests_failed++; $display("FAIL reset_resp_data: got %h, expected 0", resp_data_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_refill;
        req_vld_i        = 2'b01;
        req_wr_i         = 2'b00;
        req_addr_i[31:0] = 32'h0000_1047;
        mem_req_rdy_i    = 1'b1;
        tick();
        tests_run++; if (mem_req_vld_o !== 1'b1) begin tests_failed++; $display("FAIL refill_mem_vld: got %b, expected 1", mem_req_vld_o); end
        tests_run++; if (mem_req_addr_o !== 32'h0000_1040) begin tests_failed++; $display("FAIL refill_addr: got %h, expected 00001040", mem_req_addr_o); end
        tests_run++; if (mem_req_wr_o !== 1'b0) begin tests_failed++; $display("FAIL refill_wr: got %b, expected 0", mem_req_wr_o); end
        tick();
        tests_run++; if (mem_req_vld_o !== 1'b0) begin tests_failed++; $display("FAIL refill_vld_after_accept: got %b, expected 0", mem_req_vld_o); end
        tick();
        tick();
        tests_run++; if (resp_vld_o !== 2'b00) begin tests_failed++; $display("FAIL refill_early_resp: got %b, expected 00", resp_vld_o); end
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = {16{8'hA5}};
        tick();
        mem_resp_vld_i  = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b01) begin tests_failed++; $display("FAIL refill_resp_vld: got %b, expected 01", resp_vld_o); end
        tests_run++; if (resp_data_o !== {16{8'hA5}}) begin tests_failed++; $display("FAIL refill_resp_data: got %h, expected a5..a5", resp_data_o); end
        req_vld_i = 2'b00;
        tick();
        tests_run++; if (resp_vld_o !== 2'b00) begin tests_failed++; $display("FAIL refill_resp_one_cycle: got %b, expected 00", resp_vld_o); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL refill_idle: got %b, expected 0", busy_o); end
    endtask

    task automatic test_simultaneous;
        apply_reset();
        req_vld_i          = 2'b11;
        req_wr_i           = 2'b10;
        req_addr_i[31:0]   = 32'h0000_2000;
        req_addr_i[63:32]  = 32'h0000_3010;
        req_data_i[255:128] = {16{8'h5A}};
        mem_req_rdy_i      = 1'b1;
        tick();
        tests_run++; if (mem_req_addr_o !== 32'h0000_2000) begin tests_failed++; $display("FAIL sim_first_addr: got %h, expected 00002000", mem_req_addr_o); end
        tests_run++; if (mem_req_wr_o !== 1'b0) begin tests_failed++; $display("FAIL sim_first_wr: got %b, expected 0", mem_req_wr_o); end
        tick();
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = {16{8'h11}};
        tick();
        mem_resp_vld_i  = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b01) begin tests_failed++; $display("FAIL sim_first_resp: got %b, expected 01", resp_vld_o); end
        req_vld_i = 2'b10;
        tick();
        tick();
        tests_run++; if (mem_req_wr_o !== 1'b1) begin tests_failed++; $display("FAIL sim_second_wr: got %b, expected 1", mem_req_wr_o); end
        tests_run++; if (mem_req_addr_o !== 32'h0000_3010) begin tests_failed++; $display("FAIL sim_second_addr: got %h, expected 00003010", mem_req_addr_o); end
        tests_run++; if (mem_req_data_o !== {16{8'h5A}}) begin tests_failed++; $display("FAIL sim_second_data: got %h, expected 5a..5a", mem_req_data_o); end
        tick();
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = {16{8'hFF}};
        tick();
        mem_resp_vld_i  = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b10) begin tests_failed++; $display("FAIL sim_second_resp: got %b, expected 10", resp_vld_o); end
        tests_run++; if (resp_data_o !== {16{8'h11}}) begin tests_failed++; $display("FAIL sim_write_holds_data: got %h, expected 11..11", resp_data_o); end
        req_vld_i = 2'b00;
        tick();
        req_vld_i = 2'b11;
        req_wr_i  = 2'b00;
        tick();
        tests_run++; if (mem_req_addr_o !== 32'h0000_2000) begin tests_failed++; $display("FAIL sim_third_addr: got %h, expected 00002000", mem_req_addr_o); end
        tick();
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = {16{8'h22}};
        tick();
        mem_resp_vld_i  = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b01) begin tests_failed++; $display("FAIL sim_third_resp: got %b, expected 01", resp_vld_o); end
        req_vld_i = 2'b00;
        tick();
    endtask

    task automatic test_backpressure;
        req_vld_i           = 2'b10;
        req_wr_i            = 2'b10;
        req_addr_i[63:32]   = 32'h0000_5020;
        req_data_i[255:128] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        mem_req_rdy_i       = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (mem_req_vld_o !== 1'b1) begin tests_failed++; $display("FAIL bp_vld[%0d]: got %b, expected 1", i, mem_req_vld_o); end
            tests_run++; if (mem_req_addr_o !== 32'h0000_5020) begin tests_failed++; $display("FAIL bp_addr[%0d]: got %h, expected 00005020", i, mem_req_addr_o); end
            tests_run++; if (mem_req_data_o !== 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D) begin tests_failed++; $display("FAIL bp_data[%0d]: got %h, expected deadbeef0123456789abcdefcafef00d", i, mem_req_data_o); end
            tick();
        end
        tests_run++; if (mem_req_vld_o !== 1'b1) begin tests_failed++; $display("FAIL bp_still_issue: got %b, expected 1", mem_req_vld_o); end
        mem_req_rdy_i = 1'b1;
        tick();
        tests_run++; if (mem_req_vld_o !== 1'b0) begin tests_failed++; $display("FAIL bp_wait_entered: got %b, expected 0", mem_req_vld_o); end
        tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL bp_busy: got %b, expected 1", busy_o); end
        mem_resp_vld_i = 1'b1;
        tick();
        mem_resp_vld_i = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b10) begin tests_failed++; $display("FAIL bp_resp: got %b, expected 10", resp_vld_o); end
        req_vld_i = 2'b00;
        tick();
    endtask

    task automatic test_timeout;
        apply_reset();
        req_vld_i        = 2'b01;
        req_wr_i         = 2'b00;
        req_addr_i[31:0] = 32'h0000_6000;
        mem_req_rdy_i    = 1'b1;
        tick();
        tick();
        repeat (7) tick();
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL tmo_err_early: got %b, expected 0", err_o); end
        tick();
        tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL tmo_err_set: got %b, expected 1", err_o); end
        tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL tmo_still_busy: got %b, expected 1", busy_o); end
        tests_run++; if (mem_req_vld_o !== 1'b0) begin tests_failed++; $display("FAIL tmo_no_reissue: got %b, expected 0", mem_req_vld_o); end
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = {16{8'h77}};
        tick();
        mem_resp_vld_i  = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b01) begin tests_failed++; $display("FAIL tmo_late_resp: got %b, expected 01", resp_vld_o); end
        tests_run++; if (resp_data_o !== {16{8'h77}}) begin tests_failed++; $display("FAIL tmo_late_data: got %h, expected 77..77", resp_data_o); end
        req_vld_i = 2'b00;
        tick();
        tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL tmo_err_sticky: got %b, expected 1", err_o); end
    endtask

    task automatic test_spurious;
        apply_reset();
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = {16{8'h99}};
        tick();
        mem_resp_vld_i  = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b00) begin tests_failed++; $display("FAIL spur_resp_vld: got %b, expected 00", resp_vld_o); end
        tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL spur_err: got %b, expected 1", err_o); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL spur_busy: got %b, expected 0", busy_o); end
        tick();
        tests_run++; if (resp_vld_o !== 2'b00) begin tests_failed++; $display("FAIL spur_resp_later: got %b, expected 00", resp_vld_o); end
    endtask

    task automatic test_reset_mid_wait;
        req_vld_i         = 2'b10;
        req_wr_i          = 2'b00;
        req_addr_i[63:32] = 32'h0000_8000;
        mem_req_rdy_i     = 1'b1;
        tick();
        tick();
        tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_busy: got %b, expected 1", busy_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b, expected 0", busy_o); end
        tests_run++; if (mem_req_vld_o !== 1'b0) begin tests_failed++; $display("FAIL rst_async_mem_vld: got %b, expected 0", mem_req_vld_o); end
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL rst_async_err: got %b, expected 0", err_o); end
        req_vld_i = 2'b00;
        tick();
        rst_ni = 1'b1;
        req_vld_i        = 2'b01;
        req_wr_i         = 2'b01;
        req_addr_i[31:0] = 32'h0000_7000;
        req_data_i[127:0] = {16{8'h3C}};
        tick();
        tests_run++; if (mem_req_wr_o !== 1'b1) begin tests_failed++; $display("FAIL rst_fresh_wr: got %b, expected 1", mem_req_wr_o); end
        tests_run++; if (mem_req_addr_o !== 32'h0000_7000) begin tests_failed++; $display("FAIL rst_fresh_addr: got %h, expected 00007000", mem_req_addr_o); end
        tests_run++; if (mem_req_data_o !== {16{8'h3C}}) begin tests_failed++; $display("FAIL rst_fresh_data: got %h, expected 3c..3c", mem_req_data_o); end
        tick();
        mem_resp_vld_i = 1'b1;
        tick();
        mem_resp_vld_i = 1'b0;
        tests_run++; if (resp_vld_o !== 2'b01) begin tests_failed++; $display("FAIL rst_fresh_resp: got %b, expected 01", resp_vld_o); end
        tests_run++; if (resp_data_o !== '0) begin tests_failed++; $display("FAIL rst_fresh_resp_data: got %h, expected 0", resp_data_o); end
        req_vld_i = 2'b00;
        tick();
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL rst_fresh_idle: got %b, expected 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_single_refill();
        test_simultaneous();
        test_backpressure();
        test_timeout();
        test_spurious();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
